// File: rtl/dma_burst_stream.sv
// Descriptor-driven DRAM read DMA: queued descriptors become Wishbone burst
// reads, and returned beats stream to the accelerator through a FWFT buffer.
module dma_burst_stream #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_W     = 8,
    parameter int         DESC_DEPTH = 4,
    parameter int         BURST_LEN  = 4,
    parameter int         OBUF_DEPTH = 8,
    parameter logic [9:0] ADR_HI     = 10'h1E0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [2*ADDR_W+3:0]     desc_data_i,
    output logic                    dram_cyc_o,
    output logic                    dram_stb_o,
    output logic                    dram_we_o,
    output logic [31:0]             dram_adr_o,
    output logic [1:0]              dram_fun_sel_o,
    input  logic                    dram_ack_i,
    input  logic                    dram_burst_en_i,
    input  logic [DATA_WIDTH-1:0]   dram_dat_i,
    output logic                    acc_valid_o,
    input  logic                    acc_ready_i,
    output logic [DATA_WIDTH-1:0]   acc_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int DW  = 2*ADDR_W + 4;
    localparam int DPW = $clog2(DESC_DEPTH);
    localparam int OPW = $clog2(OBUF_DEPTH);
    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam int PAD = 32 - 12 - ADDR_W;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, BURST} state_t;

    state_t state;

    // ---------------- descriptor FIFO ----------------
    logic [DW-1:0]  desc_mem [DESC_DEPTH];
    logic [DPW-1:0] desc_wp, desc_rp;
    logic [DPW:0]   desc_cnt;
    logic           desc_full, desc_empty, desc_push, desc_pop;
    logic [DW-1:0]  desc_head;

    assign desc_full    = (desc_cnt == (DPW+1)'(DESC_DEPTH));
    assign desc_empty   = (desc_cnt == '0);
    assign desc_ready_o = ~desc_full;
    assign desc_push    = desc_valid_i & ~desc_full;
    assign desc_pop     = (state == IDLE) & ~desc_empty;
    assign desc_head    = desc_mem[desc_rp];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            desc_wp  <= '0;
            desc_rp  <= '0;
            desc_cnt <= '0;
        end else begin
            if (desc_push) desc_wp <= desc_wp + 1'b1;
            if (desc_pop)  desc_rp <= desc_rp + 1'b1;
            case ({desc_push, desc_pop})
                2'b10:   desc_cnt <= desc_cnt + 1'b1;
                2'b01:   desc_cnt <= desc_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (desc_push) desc_mem[desc_wp] <= desc_data_i;
    end

    // ---------------- output buffer (FWFT) ----------------
    logic [DATA_WIDTH-1:0] obuf_mem [OBUF_DEPTH];
    logic [OPW-1:0]        obuf_wp, obuf_rp;
    logic [OPW:0]          obuf_cnt;
    logic                  obuf_empty, obuf_push, obuf_pop, obuf_room;
    logic                  done_flag;

    assign obuf_empty  = (obuf_cnt == '0);
    assign obuf_push   = (state == BURST) & dram_burst_en_i & ~done_flag;
    assign obuf_pop    = ~obuf_empty & acc_ready_i;
    assign obuf_room   = (obuf_cnt <= (OPW+1)'(OBUF_DEPTH - BURST_LEN));
    assign acc_valid_o = ~obuf_empty;
    assign acc_data_o  = obuf_empty ? '0 : obuf_mem[obuf_rp];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            obuf_wp  <= '0;
            obuf_rp  <= '0;
            obuf_cnt <= '0;
        end else begin
            if (obuf_push) obuf_wp <= obuf_wp + 1'b1;
            if (obuf_pop)  obuf_rp <= obuf_rp + 1'b1;
            case ({obuf_push, obuf_pop})
                2'b10:   obuf_cnt <= obuf_cnt + 1'b1;
                2'b01:   obuf_cnt <= obuf_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (obuf_push) obuf_mem[obuf_wp] <= dram_dat_i;
    end

    // ---------------- control FSM ----------------
    logic [1:0]        fun_r, bank_r;
    logic [ADDR_W-1:0] cur_addr, end_addr;
    logic [BCW-1:0]    beat_cnt;
    logic              hit_end, beat_last;

    assign hit_end   = (cur_addr == end_addr);
    assign beat_last = (beat_cnt == BCW'(BURST_LEN - 1));
    assign dram_we_o = 1'b0;
    assign busy_o    = (state != IDLE) | ~desc_empty | ~obuf_empty;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            fun_r          <= '0;
            bank_r         <= '0;
            cur_addr       <= '0;
            end_addr       <= '0;
            beat_cnt       <= '0;
            done_flag      <= 1'b0;
            dram_cyc_o     <= 1'b0;
            dram_stb_o     <= 1'b0;
            dram_adr_o     <= '0;
            dram_fun_sel_o <= '0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    // cur_addr temporarily holds base until LOAD validates it
                    if (!desc_empty) begin
                        fun_r    <= desc_head[DW-1 -: 2];
                        bank_r   <= desc_head[DW-3 -: 2];
                        cur_addr <= desc_head[2*ADDR_W-1 -: ADDR_W];
                        end_addr <= desc_head[ADDR_W-1:0];
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    dram_fun_sel_o <= fun_r;
                    done_flag      <= 1'b0;
                    if (cur_addr > end_addr) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (obuf_room) begin
                        dram_cyc_o <= 1'b1;
                        dram_stb_o <= 1'b1;
                        dram_adr_o <= {ADR_HI, {PAD{1'b0}}, bank_r, cur_addr};
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dram_ack_i) begin
                        dram_cyc_o <= 1'b0;
                        dram_stb_o <= 1'b0;
                        dram_adr_o <= '0;
                        beat_cnt   <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (dram_burst_en_i) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (!done_flag) begin
                            cur_addr <= cur_addr + ADDR_W'(4);
                            if (hit_end) begin
                                done_o    <= 1'b1;
                                done_flag <= 1'b1;
                            end
                        end
                        if (beat_last)
                            state <= (done_flag || hit_end) ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_stream.sv
// Scoreboard bench for dma_burst_stream: descriptors expand into expected
// request addresses and beat data; monitors pop and compare as the DUT emits.
module tb_dma_burst_stream;
    localparam int BL = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [19:0] desc_data_i = '0;
    logic        dram_cyc_o, dram_stb_o, dram_we_o;
    logic [31:0] dram_adr_o;
    logic [1:0]  dram_fun_sel_o;
    logic        dram_ack_i = 1'b0;
    logic        dram_burst_en_i = 1'b0;
    logic [31:0] dram_dat_i = '0;
    logic        acc_valid_o;
    logic        acc_ready_i = 1'b1;
    logic [31:0] acc_data_o;
    logic        busy_o, done_o, err_o;

    dma_burst_stream dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_data_i(desc_data_i),
        .dram_cyc_o(dram_cyc_o), .dram_stb_o(dram_stb_o), .dram_we_o(dram_we_o),
        .dram_adr_o(dram_adr_o), .dram_fun_sel_o(dram_fun_sel_o), .dram_ack_i(dram_ack_i),
        .dram_burst_en_i(dram_burst_en_i), .dram_dat_i(dram_dat_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_data_o(acc_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {logic [31:0] adr; logic [1:0] fun;} req_t;

    logic [31:0] exp_q[$];
    req_t        req_q[$];
    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
    int reqs_seen = 0, beat_idx = -1, rdy_mode = 1;
    logic [31:0] last_adr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [1:0] bank, input logic [7:0] addr);
        return {4'hD, 2'b00, bank, 8'h00, addr, addr ^ 8'hA5};
    endfunction

    // Reference: a descriptor is the word sequence base, base+4 .. end,
    // fetched as ceil(words/BL) requests stepping 4*BL bytes.
    task automatic model_desc(input int fun, input int bank, input int base, input int end_a);
        req_t r;
        int   n;
        if (base > end_a) begin
            exp_err++;
        end else begin
            n = (end_a - base) / 4 + 1;
            for (int i = 0; i < n; i++)
                exp_q.push_back(beat_data(2'(bank), 8'(base + 4*i)));
            for (int k = 0; k < (n + BL - 1) / BL; k++) begin
                r.adr = 32'h7800_0000 + 32'(bank * 256) + 32'((base + 4*BL*k) % 256);
                r.fun = 2'(fun);
                req_q.push_back(r);
            end
            exp_done++;
        end
    endtask

    task automatic try_push(input int fun, input int bank, input int base, input int end_a,
                            output bit ok);
        desc_data_i  = {2'(fun), 2'(bank), 8'(base), 8'(end_a)};
        desc_valid_i = 1'b1;
        ok = desc_ready_o;
        if (ok) model_desc(fun, bank, base, end_a);
        @(posedge wb_clk_i); #1;
        desc_valid_i = 1'b0;
    endtask

    task automatic push_wait(input int fun, input int bank, input int base, input int end_a);
        bit ok = 0;
        for (int t = 0; t < 300 && !ok; t++) try_push(fun, bank, base, end_a, ok);
        chk("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_o || exp_q.size() != 0 || req_q.size() != 0) && t < 4000) begin
            @(posedge wb_clk_i); #1;
            t++;
        end
        @(negedge wb_clk_i); #1;
        chk({name, "_drain"}, 32'(t < 4000), 32'd1);
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ctl"}, {22'd0, desc_ready_o, dram_cyc_o, dram_stb_o, dram_we_o,
             dram_fun_sel_o, acc_valid_o, busy_o, done_o, err_o}, 32'h200);
        chk({name, "_adr"}, dram_adr_o, 32'd0);
        chk({name, "_data"}, acc_data_o, 32'd0);
    endtask

    // accelerator-side monitor
    initial forever begin
        @(negedge wb_clk_i);
        if (!wb_rst_i) begin
            if (acc_valid_o && acc_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL acc_unexpected act=%h exp=none", acc_data_o);
                end else begin
                    chk("acc_data", acc_data_o, exp_q.pop_front());
                end
            end
            if (done_o) done_cnt++;
            if (err_o)  err_cnt++;
            if (!dram_stb_o) chk("adr_zero_no_stb", dram_adr_o, 32'd0);
        end
    end

    // accelerator ready driver
    initial forever begin
        @(posedge wb_clk_i); #1;
        acc_ready_i = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // DRAM responder: checks each request against the model, returns BL beats
    initial forever begin
        req_t        r;
        logic [31:0] a;
        @(posedge wb_clk_i); #1;
        if (dram_stb_o && !wb_rst_i) begin
            repeat ($urandom_range(0, 2)) begin @(posedge wb_clk_i); #1; end
            a = dram_adr_o;
            last_adr = a;
            reqs_seen++;
            chk("req_cyc_we", {30'd0, dram_cyc_o, dram_we_o}, 32'd2);
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected act=%h exp=none", a);
            end else begin
                r = req_q.pop_front();
                chk("req_adr", a, r.adr);
                chk("req_fun", {30'd0, dram_fun_sel_o}, {30'd0, r.fun});
            end
            dram_ack_i = 1'b1;
            @(posedge wb_clk_i); #1;
            dram_ack_i = 1'b0;
            for (int i = 0; i < BL; i++) begin
                repeat ($urandom_range(0, 1)) begin @(posedge wb_clk_i); #1; end
                beat_idx        = i;
                dram_burst_en_i = 1'b1;
                dram_dat_i      = beat_data(a[9:8], 8'(a[7:0] + 8'(4*i)));
                @(posedge wb_clk_i); #1;
                dram_burst_en_i = 1'b0;
                if (wb_rst_i) break;
            end
            beat_idx = -1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc, r0, hit, n, base, end_a;

        repeat (2) @(negedge wb_clk_i);
        chk_reset_outs("reset");
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;

        // 1: single 4-beat burst
        push_wait(0, 2, 'h00, 'h0C);
        wait_idle("t1");
        chk("t1_adr", last_adr, 32'h7800_0200);

        // 2: 2-beat descriptor, tail of burst dropped
        r0 = reqs_seen;
        push_wait(1, 1, 'h00, 'h04);
        wait_idle("t2");
        chk("t2_reqs", 32'(reqs_seen - r0), 32'd1);

        // 3: fill descriptor FIFO behind a long descriptor
        push_wait(0, 3, 'h40, 'h7C);
        repeat (2) @(posedge wb_clk_i);
        #1;
        acc = 0;
        for (int j = 0; j < 5; j++) begin
            try_push(j % 4, (j + 1) % 4, 'h80 + 4*j, 'h80 + 4*j, ok);
            if (ok) acc++;
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        wait_idle("t3");

        // 4: backpressure stalls after two bursts fill the buffer
        rdy_mode = 0;
        r0 = reqs_seen;
        push_wait(2, 1, 'h00, 'h3C);
        repeat (80) @(posedge wb_clk_i);
        #1;
        chk("t4_reqs_stalled", 32'(reqs_seen - r0), 32'd2);
        chk("t4_stb_low", 32'(dram_stb_o), 32'd0);
        chk("t4_valid", 32'(acc_valid_o), 32'd1);
        rdy_mode = 1;
        wait_idle("t4");
        chk("t4_reqs_total", 32'(reqs_seen - r0), 32'd4);

        // 5: base > end
        r0 = reqs_seen;
        push_wait(3, 0, 'h10, 'h08);
        wait_idle("t5");
        chk("t5_no_req", 32'(reqs_seen - r0), 32'd0);

        // 6: reset during the second beat of a burst
        push_wait(0, 1, 'h00, 'h3C);
        hit = 0;
        for (int t = 0; t < 300 && hit == 0; t++) begin
            @(posedge wb_clk_i); #2;
            if (dram_burst_en_i && beat_idx == 1) hit = 1;
        end
        chk("t6_reached_beat2", 32'(hit), 32'd1);
        wb_rst_i = 1'b1;
        exp_q.delete();
        req_q.delete();
        @(negedge wb_clk_i);
        chk_reset_outs("t6_reset");
        @(posedge wb_clk_i); #2;
        @(posedge wb_clk_i); #2;
        wb_rst_i = 1'b0;
        exp_done = done_cnt;
        exp_err  = err_cnt;
        @(posedge wb_clk_i); #1;
        push_wait(2, 0, 'h20, 'h2C);
        wait_idle("t6_after");

        // randomized descriptors with random backpressure
        rdy_mode = 2;
        for (int d = 0; d < 24; d++) begin
            n = $urandom_range(1, 12);
            base = 4 * $urandom_range(0, 63 - (n - 1));
            end_a = base + 4 * (n - 1);
            if ($urandom_range(0, 7) == 0) begin
                end_a = 4 * $urandom_range(0, 50);
                base  = end_a + 4 * $urandom_range(1, 5);
            end
            push_wait($urandom_range(0, 3), $urandom_range(0, 3), base, end_a);
            repeat ($urandom_range(0, 6)) @(posedge wb_clk_i);
            #1;
        end
        wait_idle("rand");
        rdy_mode = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
